training_sequencer: RTL
=======================

# training_sequencer

Training controller that sits directly downstream and upstream of a learning neuron. It holds a small buffer of labelled samples and presents them to the neuron one at a time, epoch by epoch. For each sample it computes the error term `target - axon`, drives it as the neuron's backprop input, and issues one commit pulse that the integration uses as the neuron's clock. It stops after a fixed epoch count or, optionally, when epoch squared error falls below a threshold.

## Interface
- `N_SAMPLES`, 16: buffer depth, 1..256.
- `N_INPUTS`, 32: dendrite count. Must match the neuron's dendrite count.
- `MAX_EPOCHS`, 1000: hard epoch limit, 1..65535.
- `SETTLE_CYCLES`, 2: cycles the dendrites are held before the error is captured, ≥1.

Ports:
- `ts_clock` in, 1: single clock, rising-edge.
- `ts_reset_n` in, 1: asynchronous, active-low reset.
- `ts_load_valid` in, 1 / `ts_load_ready` out, 1: sample-load handshake.
- `ts_load_inputs` in, real[N_INPUTS-1:0]: sample inputs.
- `ts_load_target` in, real: sample target.
- `ts_clear` in, 1: empties the buffer. Honoured in IDLE/DONE only.
- `ts_start` in, 1: begins training. Level-sampled in IDLE/DONE.
- `ts_training_ratio` in, real: learning rate.
- `ts_error_threshold` in, real: SSE stop threshold.
- `ts_axon` in, real: neuron output.
- `ts_dendrites` out, real[N_INPUTS-1:0]: presented sample.
- `ts_backprop` out, real: registered error term.
- `ts_ratio_out` out, real: learning rate gated to the commit cycle.
- `ts_commit` out, 1: one-cycle pulse. Its falling edge commits the neuron's weights.
- `ts_busy`, `ts_done`, `ts_converged` out, 1 each: status flags.
- `ts_epoch_count` out, 16: completed epochs.
- `ts_epoch_sse` out, real: sum of squared errors of the last completed epoch.

## Operation
- **States:** IDLE, PRESENT, COMMIT, ADVANCE, EPOCH_END, DONE.
- **Load:**
  - `ts_load_ready` = (state ∈ {IDLE, DONE}) && count < N_SAMPLES.
  - A transfer occurs when valid && ready. It writes entry[count] and increments count.
  - `ts_clear` takes priority over a simultaneous load: count becomes 0, no write.
- **IDLE/DONE → PRESENT:** when `ts_start` && count > 0.
  - Clears index, epoch count, SSE accumulator and `ts_done`.
  - Starting with count = 0 is ignored and the state is unchanged.
- **PRESENT:** `ts_dendrites` is loaded with entry[index] on entry. Held for SETTLE_CYCLES cycles.
  - On the last settle cycle: `ts_backprop` <= target - `ts_axon`; accumulator += (target - `ts_axon`)².
  - Then go to COMMIT.
- **COMMIT:** `ts_commit` = 1 and `ts_ratio_out` = `ts_training_ratio` for exactly one cycle. Outside COMMIT, `ts_ratio_out` = 0.0.
- **ADVANCE:**
  - If index == count-1: go to EPOCH_END.
  - Otherwise index++ and go to PRESENT.
- **EPOCH_END:**
  - `ts_epoch_count`++.
  - `ts_epoch_sse` <= accumulator, then the accumulator is cleared and index is set to 0.
  - Go to DONE if the epoch count reaches MAX_EPOCHS, or if the SSE check passes (see Configuration).
  - Otherwise go to PRESENT.
- **DONE:** `ts_done` = 1. Dendrites and backprop are held. `ts_start` re-runs training on the existing buffer; a new start resets the epoch count to 0.
- `ts_busy` = state ∉ {IDLE, DONE}.
- **Async reset:** state IDLE, count 0, index 0, and all outputs at their reset values. This includes reset arriving mid-epoch. In-flight commits are abandoned and the buffer contents are don't-care.
- `ts_start`, `ts_load_valid` and `ts_clear` are ignored while busy. `ts_load_ready` stays 0 while busy.

## Timing
- **Reset values:** `ts_load_ready` = 1; `ts_dendrites` all 0.0; `ts_backprop` 0.0; `ts_ratio_out` 0.0; `ts_commit` 0; `ts_busy` 0; `ts_done` 0; `ts_converged` 0; `ts_epoch_count` 0; `ts_epoch_sse` 0.0.
- Start is sampled at edge t. PRESENT begins at t+1, and the first dendrites are visible after t+1.
- **Per sample:** SETTLE_CYCLES + 2 cycles (PRESENT ×S, COMMIT, ADVANCE).
- **Per epoch:** count·(S+2) + 1 cycles.
- `ts_backprop` updates at the edge that ends PRESENT and is stable throughout COMMIT.
- `ts_commit` rises on a rising edge and falls one cycle later. The neuron commits on that falling edge, mid-cycle relative to the next sample.
- **Epoch count width:** 16 bits. MAX_EPOCHS ≤ 65535, so the counter never wraps.
- `ts_done` and `ts_converged` assert in the cycle after EPOCH_END.

## Configuration
- **`TS_SSE_EN` defined:**
  - The SSE is accumulated.
  - DONE is also taken at EPOCH_END when the new SSE < `ts_error_threshold`, and `ts_converged` is set.
  - `ts_converged` clears on start.
- **`TS_SSE_EN` undefined:**
  - There is no accumulator. `ts_epoch_sse` is tied to 0.0 and `ts_converged` is tied to 0.
  - Training always runs exactly MAX_EPOCHS epochs.

## Structure
- **Package `ts_pkg`:**
  - State enum `ts_state_t`.
  - Default constants for N_INPUTS and MAX_EPOCHS.
  - Sample struct `ts_sample_t` {real inputs[N_INPUTS], real target}.
- **Sub-module `ts_sample_buffer`:** N_SAMPLES entries, one write port (count pointer, clear) and one read port (index). The FSM, arithmetic and outputs live in `training_sequencer`.

## Test plan
- **Reset mid-epoch:** start with 4 samples, assert `ts_reset_n` = 0 during the second PRESENT → immediately IDLE, `ts_busy` 0, `ts_load_ready` 1, `ts_commit` 0, epoch count 0.
- **Load full buffer:** load 16 samples back-to-back → `ts_load_ready` drops after the 16th. A 17th valid is not accepted. `ts_clear` concurrent with valid → count 0.
- **Fixed-epoch run:** 2 samples, S = 2, MAX_EPOCHS = 3, SSE disabled → exactly 6 commit pulses, `ts_done` at cycle 3·(2·4+1)+1 = 28 after start, `ts_epoch_count` = 3.
- **Error term:** target 1.0, forced axon 0.25 → `ts_backprop` = 0.75 during COMMIT, `ts_ratio_out` = training ratio only in that cycle.
- **Early stop (`TS_SSE_EN`):** forced axon equals target, threshold 0.01 → DONE after epoch 1, `ts_converged` 1, `ts_epoch_sse` 0.0.
- **Degenerate start:** start with count 0 → stays IDLE. Restart from DONE → epoch count resets to 0 and `ts_done` clears.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared types and defaults for the training sequencer.
package ts_pkg;

   localparam int unsigned TS_N_INPUTS   = 32;
   localparam int unsigned TS_MAX_EPOCHS = 1000;

   typedef enum logic [2:0] {
      StIdle,
      StPresent,
      StCommit,
      StAdvance,
      StEpochEnd,
      StDone
   } ts_state_t;

   typedef struct {
      real inputs [TS_N_INPUTS];
      real target;
   } ts_sample_t;

endpackage

// File: rtl/ts_sample_buffer.sv
// Labelled-sample store: append-only write port driven by the fill count, one
// combinational read port.
module ts_sample_buffer #(
   parameter int unsigned N_SAMPLES = 16,
   parameter int unsigned N_INPUTS  = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wr_en,
   input  logic clear,
   input  real  wr_inputs [N_INPUTS],
   input  real  wr_target,
   input  logic [((N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1)-1:0] rd_idx,
   output real  rd_inputs [N_INPUTS],
   output real  rd_target,
   output logic [$clog2(N_SAMPLES + 1)-1:0] count
);

   localparam int unsigned IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

   real in_mem  [N_SAMPLES][N_INPUTS];
   real tgt_mem [N_SAMPLES];

   logic [IDX_W-1:0] wr_ptr;
   assign wr_ptr = count[IDX_W-1:0];

   // Contents are not reset; only the fill count defines what is valid.
   always_ff @(posedge clk) begin
      if (wr_en && !clear) begin
         for (int j = 0; j < N_INPUTS; j++) begin
            in_mem[wr_ptr][j] <= wr_inputs[j];
         end
         tgt_mem[wr_ptr] <= wr_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (wr_en) begin
         count <= count + 1'b1;
      end
   end

   always_comb begin
      for (int j = 0; j < N_INPUTS; j++) begin
         rd_inputs[j] = in_mem[rd_idx][j];
      end
      rd_target = tgt_mem[rd_idx];
   end

endmodule

// File: rtl/training_sequencer.sv
// Presents buffered samples to a learning neuron epoch by epoch and pulses commit per sample.
// Define TS_SSE_EN to accumulate epoch squared error and stop early below a threshold.
module training_sequencer
   import ts_pkg::*;
#(
   parameter int unsigned N_SAMPLES     = 16,
   parameter int unsigned N_INPUTS      = TS_N_INPUTS,
   parameter int unsigned MAX_EPOCHS    = TS_MAX_EPOCHS,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        ts_clock,
   input  logic        ts_reset_n,
   input  logic        ts_load_valid,
   output logic        ts_load_ready,
   input  real         ts_load_inputs [N_INPUTS],
   input  real         ts_load_target,
   input  logic        ts_clear,
   input  logic        ts_start,
   input  real         ts_training_ratio,
   input  real         ts_error_threshold,
   input  real         ts_axon,
   output real         ts_dendrites [N_INPUTS],
   output real         ts_backprop,
   output real         ts_ratio_out,
   output logic        ts_commit,
   output logic        ts_busy,
   output logic        ts_done,
   output logic        ts_converged,
   output logic [15:0] ts_epoch_count,
   output real         ts_epoch_sse
);

   localparam int unsigned IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);
   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [15:0]      EPOCH_LAST  = 16'(MAX_EPOCHS);

   ts_state_t        state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, last_idx;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [15:0]      epoch_q, epoch_d;
   logic             done_q, done_d;
   logic             start_q;
   logic             idle_or_done, wr_en, clear_en;
   logic             capture, epoch_end, run_start, load_dend, sse_stop;
   logic [CNT_W-1:0] count;
   real              rd_inputs [N_INPUTS];
   real              rd_target;
   real              dend_q [N_INPUTS];
   real              target_q, backprop_q, err;

   assign idle_or_done  = (state_q == StIdle) || (state_q == StDone);
   assign ts_load_ready = idle_or_done && (count < CNT_W'(N_SAMPLES));
   assign clear_en      = idle_or_done && ts_clear;
   assign wr_en         = ts_load_valid && ts_load_ready;
   assign last_idx      = IDX_W'(count - CNT_W'(1));

   ts_sample_buffer #(
      .N_SAMPLES (N_SAMPLES),
      .N_INPUTS  (N_INPUTS)
   ) u_buffer (
      .clk       (ts_clock),
      .rst_n     (ts_reset_n),
      .wr_en     (wr_en),
      .clear     (clear_en),
      .wr_inputs (ts_load_inputs),
      .wr_target (ts_load_target),
      .rd_idx    (idx_d),
      .rd_inputs (rd_inputs),
      .rd_target (rd_target),
      .count     (count)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      settle_d  = settle_q;
      epoch_d   = epoch_q;
      done_d    = done_q;
      capture   = 1'b0;
      epoch_end = 1'b0;
      run_start = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            // A clear in the same cycle empties the buffer, so it wins over start.
            if (start_q && (count != '0) && !ts_clear) begin
               run_start = 1'b1;
               state_d   = StPresent;
               idx_d     = '0;
               epoch_d   = '0;
               done_d    = 1'b0;
            end
         end
         StPresent: begin
            if (settle_q == SETTLE_LAST) begin
               capture = 1'b1;
               state_d = StCommit;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         StCommit: begin
            settle_d = '0;
            state_d  = StAdvance;
         end
         StAdvance: begin
            if (idx_q == last_idx) begin
               state_d = StEpochEnd;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = StPresent;
            end
         end
         StEpochEnd: begin
            epoch_end = 1'b1;
            epoch_d   = epoch_q + 16'd1;
            idx_d     = '0;
            if ((epoch_d == EPOCH_LAST) || sse_stop) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else begin
               state_d = StPresent;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign load_dend = (state_d == StPresent) && (state_q != StPresent);

   always_comb err = target_q - ts_axon;

   always_ff @(posedge ts_clock or negedge ts_reset_n) begin
      if (!ts_reset_n) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         settle_q   <= '0;
         epoch_q    <= '0;
         done_q     <= 1'b0;
         start_q    <= 1'b0;
         target_q   <= 0.0;
         backprop_q <= 0.0;
         for (int j = 0; j < N_INPUTS; j++) begin
            dend_q[j] <= 0.0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         epoch_q  <= epoch_d;
         done_q   <= done_d;
         start_q  <= ts_start && !ts_busy;
         if (load_dend) begin
            for (int j = 0; j < N_INPUTS; j++) begin
               dend_q[j] <= rd_inputs[j];
            end
            target_q <= rd_target;
         end
         if (capture) begin
            backprop_q <= err;
         end
      end
   end

`ifdef TS_SSE_EN
   real  acc_q, sse_q;
   logic conv_q;

   always_ff @(posedge ts_clock or negedge ts_reset_n) begin
      if (!ts_reset_n) begin
         acc_q  <= 0.0;
         sse_q  <= 0.0;
         conv_q <= 1'b0;
      end else if (run_start) begin
         acc_q  <= 0.0;
         conv_q <= 1'b0;
      end else if (capture) begin
         acc_q <= acc_q + err * err;
      end else if (epoch_end) begin
         acc_q <= 0.0;
         sse_q <= acc_q;
         if (sse_stop) begin
            conv_q <= 1'b1;
         end
      end
   end

   assign sse_stop     = (acc_q < ts_error_threshold);
   assign ts_epoch_sse = sse_q;
   assign ts_converged = conv_q;
`else
   logic unused_threshold;
   assign unused_threshold = (ts_error_threshold != 0.0) || run_start || epoch_end;
   assign sse_stop         = 1'b0;
   assign ts_epoch_sse     = 0.0;
   assign ts_converged     = 1'b0;
`endif

   assign ts_dendrites   = dend_q;
   assign ts_backprop    = backprop_q;
   assign ts_commit      = (state_q == StCommit);
   assign ts_ratio_out   = ts_commit ? ts_training_ratio : 0.0;
   assign ts_busy        = !idle_or_done;
   assign ts_done        = done_q;
   assign ts_epoch_count = epoch_q;

endmodule
